// File: rtl/pc_sequencer.sv
// PC sequencer: next-PC selection, trap/mret redirection, misalignment
// detection and a circular return-address stack that tracks jal/ret pairs.
module pc_sequencer #(
    parameter int unsigned     XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TVEC_RESET   = {{(XLEN-9){1'b0}}, 9'h100},
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic [2:0]      pc_src,
    input  logic            zero,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    input  logic            trap_req,
    input  logic            tvec_we,
    input  logic [XLEN-1:0] tvec_wdata,
    output logic [XLEN-1:0] pc_current,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] epc,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            misaligned_fault
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [XLEN-1:0] PC_STEP   = {{(XLEN-3){1'b0}}, 3'd4};
    localparam logic [XLEN-1:0] BIT0_MASK = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        PcSeq  = 3'b000,
        PcBeq  = 3'b001,
        PcBne  = 3'b010,
        PcJal  = 3'b011,
        PcJalr = 3'b100,
        PcRet  = 3'b101,
        PcMret = 3'b110,
        PcRsvd = 3'b111
    } pc_src_e;

    // Architectural state
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_epc;
    logic [XLEN-1:0]  r_tvec;
    logic             r_fault;
    logic [XLEN-1:0]  r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_ras_ptr;   // next slot to write; top of stack is ptr-1
    logic [CNT_W-1:0] r_ras_cnt;

    // Next-PC datapath
    logic [XLEN-1:0]  w_pc_plus4;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_jalr_target;
    logic [PTR_W-1:0] w_ras_top_idx;
    logic [XLEN-1:0]  w_ras_top;
    logic [XLEN-1:0]  w_next_pc;
    logic             w_push_req;
    logic             w_pop_req;
    logic             w_misaligned;
    logic             w_redirect;
    logic             w_advance;
    logic             w_do_push;
    logic             w_do_pop;
    logic [XLEN-1:0]  w_tvec_wdata;

    assign w_pc_plus4    = r_pc + PC_STEP;
    assign w_target      = r_pc + imm;
    assign w_jalr_target = alu_result & BIT0_MASK;
    assign w_ras_top_idx = r_ras_ptr - PTR_W'(1);
    assign w_ras_top     = r_ras[w_ras_top_idx];
    assign w_tvec_wdata  = tvec_wdata & WORD_MASK;

    // Decode pc_src into the candidate next PC and the requested RAS operation
    always_comb begin
        w_next_pc  = w_pc_plus4;
        w_push_req = 1'b0;
        w_pop_req  = 1'b0;
        unique case (pc_src_e'(pc_src))
            PcSeq: w_next_pc = w_pc_plus4;
            PcBeq: begin
                if (zero) w_next_pc = w_target;
            end
            PcBne: begin
                if (!zero) w_next_pc = w_target;
            end
            PcJal: begin
                w_next_pc  = w_target;
                w_push_req = 1'b1;
            end
            PcJalr: w_next_pc = w_jalr_target;
            PcRet: begin
                if (r_ras_cnt != '0) begin
                    w_next_pc = w_ras_top;
                    w_pop_req = 1'b1;
                end else begin
                    // Empty stack: fall back to the computed return address
                    w_next_pc = w_jalr_target;
                end
            end
            PcMret: w_next_pc = r_epc;
            PcRsvd: w_next_pc = w_pc_plus4;
            default: w_next_pc = w_pc_plus4;
        endcase
    end

    // Priority: trap, then stall, then misalignment, then normal advance
    assign w_misaligned = |w_next_pc[1:0];
    assign w_redirect   = trap_req || (!stall && w_misaligned);
    assign w_advance    = !trap_req && !stall && !w_misaligned;
    assign w_do_push    = w_advance && w_push_req;
    assign w_do_pop     = w_advance && w_pop_req;

    // PC, exception PC and the one-cycle misalignment pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc    <= RESET_VECTOR;
            r_epc   <= '0;
            r_fault <= 1'b0;
        end else if (w_redirect) begin
            r_pc    <= r_tvec;
            r_epc   <= r_pc;
            r_fault <= !trap_req;
        end else if (w_advance) begin
            r_pc    <= w_next_pc;
            r_fault <= 1'b0;
        end else begin
            r_fault <= 1'b0;
        end
    end

    // Trap-vector register; a same-cycle trap still sees the old value
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tvec <= TVEC_RESET;
        end else if (tvec_we) begin
            r_tvec <= w_tvec_wdata;
        end
    end

    // RAS pointer and occupancy; a push when full overwrites the oldest entry
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ras_ptr <= '0;
            r_ras_cnt <= '0;
        end else if (w_do_push) begin
            r_ras_ptr <= r_ras_ptr + PTR_W'(1);
            if (r_ras_cnt != CNT_FULL) begin
                r_ras_cnt <= r_ras_cnt + CNT_W'(1);
            end
        end else if (w_do_pop) begin
            r_ras_ptr <= w_ras_top_idx;
            r_ras_cnt <= r_ras_cnt - CNT_W'(1);
        end
    end

    // RAS storage; contents are don't-care after reset so no reset is applied
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_ras[r_ras_ptr] <= w_pc_plus4;
        end
    end

    assign pc_current       = r_pc;
    assign pc_plus4         = w_pc_plus4;
    assign epc              = r_epc;
    assign misaligned_fault = r_fault;
    assign ras_empty        = (r_ras_cnt == '0);
    assign ras_full         = (r_ras_cnt == CNT_FULL);

endmodule
